// File: rtl/obi_data_mem_responder.sv
// rtl/obi_data_mem_responder.sv - word-addressed data memory responder with grant stall and fixed-latency responses
module obi_data_mem_responder #(
    parameter int MEM_WORDS        = 1024,
    parameter int RD_LATENCY       = 2,
    parameter int MAX_OUTSTANDING  = 2,
    parameter int GNT_STALL_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);
    localparam int AW  = $clog2(MEM_WORDS);
    localparam int SCW = (GNT_STALL_CYCLES > 0) ? $clog2(GNT_STALL_CYCLES + 1) : 1;
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]                  mem [MEM_WORDS];
    logic [SCW-1:0]               stall_cnt;
    logic [OCW-1:0]               outstanding;
    logic [RD_LATENCY-1:0]        pipe_valid;
    logic [RD_LATENCY-1:0]        pipe_err;
    logic [RD_LATENCY-1:0][31:0]  pipe_rdata;
    logic [RD_LATENCY-1:0]        valid_in;
    logic [RD_LATENCY-1:0]        err_in;
    logic [RD_LATENCY-1:0][31:0]  rdata_in;
    logic [31:0]                  word_addr;
    logic [AW-1:0]                word_idx;
    logic [31:0]                  rd_word;
    logic [31:0]                  wr_word;
    logic                         out_of_range;
    logic                         stall_done;
    logic                         accept;
    logic                         retire;

    // Byte-offset bits fall away in the shift; anything above the array is out of range.
    assign word_addr    = data_addr_i >> 2;
    assign word_idx     = word_addr[AW-1:0];
    assign out_of_range = |(word_addr >> AW);

    assign stall_done = (stall_cnt == SCW'(GNT_STALL_CYCLES));
    assign data_gnt_o = !rst_i && data_req_i && stall_done
                        && (outstanding < OCW'(MAX_OUTSTANDING));
    assign accept     = data_req_i && data_gnt_o;
    assign retire     = pipe_valid[RD_LATENCY-1];

    assign rd_word = (data_we_i || out_of_range) ? 32'h0 : mem[word_idx];

    always_comb begin
        wr_word = mem[word_idx];
        for (int k = 0; k < 4; k++) begin
            if (data_be_i[k]) begin
                wr_word[8*k +: 8] = data_wdata_i[8*k +: 8];
            end
        end
    end

    // Memory contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk) begin
        if (accept && data_we_i && !out_of_range) begin
            mem[word_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (!data_req_i || accept) begin
            stall_cnt <= '0;
        end else if (!stall_done) begin
            stall_cnt <= stall_cnt + SCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            outstanding <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   outstanding <= outstanding + OCW'(1);
                2'b01:   outstanding <= outstanding - OCW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_comb begin
        valid_in    = '0;
        err_in      = '0;
        rdata_in    = '0;
        valid_in[0] = accept;
        err_in[0]   = accept && out_of_range;
        rdata_in[0] = accept ? rd_word : 32'h0;
    end

    // Stage 0 captures at the accepting edge; the last stage drives the response.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            pipe_rdata <= '0;
        end else begin
            pipe_valid <= (pipe_valid << 1) | valid_in;
            pipe_err   <= (pipe_err << 1) | err_in;
            pipe_rdata <= (pipe_rdata << 32) | rdata_in;
        end
    end

    assign data_rvalid_o = pipe_valid[RD_LATENCY-1];
    assign data_err_o    = pipe_err[RD_LATENCY-1];
    assign data_rdata_o  = pipe_rdata[RD_LATENCY-1];

endmodule

// File: tb/tb_obi_data_mem_responder.sv
// tb/tb_obi_data_mem_responder.sv - bench for obi_data_mem_responder across three parameter sets
module tb_obi_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        req    [3];
    logic [31:0] addr   [3];
    logic        we     [3];
    logic [3:0]  be     [3];
    logic [31:0] wdata  [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    obi_data_mem_responder u_def (
        .clk(clk), .rst_i(rst), .data_req_i(req[0]), .data_addr_i(addr[0]),
        .data_we_i(we[0]), .data_be_i(be[0]), .data_wdata_i(wdata[0]),
        .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]),
        .data_err_o(err[0])
    );

    obi_data_mem_responder #(.GNT_STALL_CYCLES(2)) u_stall (
        .clk(clk), .rst_i(rst), .data_req_i(req[1]), .data_addr_i(addr[1]),
        .data_we_i(we[1]), .data_be_i(be[1]), .data_wdata_i(wdata[1]),
        .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]),
        .data_err_o(err[1])
    );

    obi_data_mem_responder #(.RD_LATENCY(4), .MAX_OUTSTANDING(2)) u_lat (
        .clk(clk), .rst_i(rst), .data_req_i(req[2]), .data_addr_i(addr[2]),
        .data_we_i(we[2]), .data_be_i(be[2]), .data_wdata_i(wdata[2]),
        .data_gnt_o(gnt[2]), .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]),
        .data_err_o(err[2])
    );

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, exp);
        end
    endtask

    // Reference model: pending responses are a queue stamped with their due cycle,
    // memory is a plain array, and the grant rule is evaluated from queue occupancy.
    typedef struct {
        int          due;
        logic [31:0] rdata;
        bit          err;
        bit          known;
    } resp_t;

    for (genvar d = 0; d < 3; d++) begin : g_mdl
        localparam int LAT   = (d == 2) ? 4 : 2;
        localparam int MAXO  = 2;
        localparam int STALL = (d == 1) ? 2 : 0;
        resp_t       q [$];
        logic [31:0] mm [1024];
        bit          mk [1024];
        int          held = 0;

        always @(negedge clk) begin
            resp_t r;
            bit    eg;
            bit    ev;
            bit    oor;
            int    idx;
            if (rst) begin
                check("rst_gnt", d, gnt[d], 0);
                check("rst_rvalid", d, rvalid[d], 0);
                check("rst_rdata", d, rdata[d], 0);
                check("rst_err", d, err[d], 0);
                q.delete();
                held = 0;
            end else begin
                ev = (q.size() > 0) && (q[0].due == cyc);
                eg = req[d] && (held >= STALL) && (q.size() < MAXO);
                check("gnt", d, gnt[d], eg);
                check("rvalid", d, rvalid[d], ev);
                if (ev) begin
                    r = q.pop_front();
                    if (r.known) check("rdata", d, rdata[d], r.rdata);
                    check("err", d, err[d], r.err);
                end
                if (eg) begin
                    oor     = (addr[d] >= 32'h1000);
                    idx     = int'((addr[d] % 32'h1000) / 4);
                    r.due   = cyc + LAT;
                    r.err   = oor;
                    r.known = we[d] || oor || mk[idx];
                    r.rdata = (we[d] || oor) ? 32'h0 : mm[idx];
                    q.push_back(r);
                    if (we[d] && !oor) begin
                        for (int k = 0; k < 4; k++)
                            if (be[d][k]) mm[idx][8*k +: 8] = wdata[d][8*k +: 8];
                        if (be[d] == 4'hF) mk[idx] = 1'b1;
                    end
                    held = 0;
                end else begin
                    held = req[d] ? held + 1 : 0;
                end
            end
        end
    end

    task automatic do_txn(input int d, input bit w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int gwait, output int lat);
        bit got  = 0;
        bit gotr = 0;
        int acc  = 0;
        rd = 'x; er = 'x; gwait = 0; lat = -1;
        @(posedge clk); #1;
        req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (gnt[d]) begin
                got = 1;
                acc = cyc;
            end else begin
                gwait++;
            end
        end
        @(posedge clk); #1;
        req[d] = 1'b0;
        if (!got) begin
            check("gnt_timeout", d, 0, 1);
        end else begin
            for (int i = 0; i < 20 && !gotr; i++) begin
                @(negedge clk);
                if (rvalid[d]) begin
                    gotr = 1;
                    rd   = rdata[d];
                    er   = err[d];
                    lat  = cyc - acc;
                end
            end
            if (!gotr) check("rvalid_timeout", d, 0, 1);
        end
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
        return a;
    endfunction

    task automatic rand_drive(input int d, input int n);
        bit granted = 1;
        for (int t = 0; t < n; t++) begin
            @(posedge clk); #1;
            if (granted || !req[d] || $urandom_range(0, 5) == 0) begin
                req[d]   = ($urandom_range(0, 3) != 0);
                we[d]    = 1'($urandom_range(0, 1));
                be[d]    = 4'($urandom);
                wdata[d] = $urandom;
                addr[d]  = rand_addr();
            end
            @(negedge clk);
            granted = req[d] && gnt[d];
        end
        @(posedge clk); #1;
        req[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [16];
        logic [31:0] rd;
        logic        er;
        int          gw;
        int          lt;
        int          gc [3];
        int          rc [3];
        logic [31:0] rdv [3];
        int          ng;
        int          nr;
        int          seen;

        tbl[0]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{1'b1, 32'h0000_0010, 4'h2, 32'h0000_AA00, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_AAEF, 1'b0};
        tbl[5]  = '{1'b0, 32'h0000_0013, 4'h0, 32'h0,         32'hDEAD_AAEF, 1'b0};
        tbl[6]  = '{1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_AAEF, 1'b0};
        tbl[8]  = '{1'b0, 32'h0000_1000, 4'h0, 32'h0,         32'h0, 1'b1};
        tbl[9]  = '{1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678, 32'h0, 1'b1};
        tbl[10] = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0};
        tbl[11] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h0,         32'h0, 1'b0};
        tbl[12] = '{1'b1, 32'h0000_0FFC, 4'h9, 32'hA1B2_C3D4, 32'h0, 1'b0};
        tbl[13] = '{1'b0, 32'h0000_0FFC, 4'h0, 32'h0,         32'hA100_00D4, 1'b0};
        tbl[14] = '{1'b0, 32'h8000_0010, 4'h0, 32'h0,         32'h0, 1'b1};
        tbl[15] = '{1'b0, 32'h0040_0010, 4'h0, 32'h0,         32'h0, 1'b1};

        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; be[d] = '0; wdata[d] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Default configuration: same-cycle grant, two-cycle response.
        for (int i = 0; i < 16; i++) begin
            do_txn(0, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, rd, er, gw, lt);
            check($sformatf("vec%0d_rdata", i), 0, rd, tbl[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 0, er, tbl[i].exp_err);
            check($sformatf("vec%0d_gwait", i), 0, gw, 0);
            check($sformatf("vec%0d_lat", i), 0, lt, 2);
        end

        // Two-cycle grant stall, and a request dropped early restarts the count.
        do_txn(1, 1'b1, 32'h20, 4'hF, 32'h1122_3344, rd, er, gw, lt);
        check("stall_store_gwait", 1, gw, 2);
        check("stall_store_lat", 1, lt, 2);
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20;
        @(negedge clk);
        check("stall_early_gnt", 1, gnt[1], 0);
        @(posedge clk); #1;
        req[1] = 1'b0;
        do_txn(1, 1'b0, 32'h20, 4'h0, 32'h0, rd, er, gw, lt);
        check("stall_load_gwait", 1, gw, 2);
        check("stall_load_rdata", 1, rd, 32'h1122_3344);

        // Reset with two loads in flight: nothing may come back afterwards.
        do_txn(2, 1'b1, 32'h40, 4'hF, 32'hAAAA_0001, rd, er, gw, lt);
        check("lat4_store_lat", 2, lt, 4);
        do_txn(2, 1'b1, 32'h44, 4'hF, 32'hAAAA_0002, rd, er, gw, lt);
        do_txn(2, 1'b1, 32'h48, 4'hF, 32'hAAAA_0003, rd, er, gw, lt);
        @(posedge clk); #1;
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h40;
        @(negedge clk);
        check("rst_seq_gnt0", 2, gnt[2], 1);
        @(posedge clk); #1;
        addr[2] = 32'h44;
        @(negedge clk);
        check("rst_seq_gnt1", 2, gnt[2], 1);
        @(posedge clk); #1;
        req[2] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rvalid[2]) seen++;
        end
        check("rst_no_rvalid", 2, seen, 0);
        do_txn(2, 1'b0, 32'h44, 4'h0, 32'h0, rd, er, gw, lt);
        check("post_rst_rdata", 2, rd, 32'hAAAA_0002);
        check("post_rst_gwait", 2, gw, 0);

        // Three back-to-back loads against a two-deep outstanding limit.
        ng = 0; nr = 0;
        @(posedge clk); #1;
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h40;
        for (int t = 0; t < 40 && nr < 3; t++) begin
            @(negedge clk);
            if (rvalid[2]) begin
                rc[nr] = cyc; rdv[nr] = rdata[2]; nr++;
            end
            if (req[2] && gnt[2] && ng < 3) begin
                gc[ng] = cyc; ng++;
            end
            @(posedge clk); #1;
            if (ng < 3) addr[2] = 32'h40 + 32'(ng) * 4;
            else        req[2] = 1'b0;
        end
        req[2] = 1'b0;
        check("b2b_grants", 2, ng, 3);
        check("b2b_rvalids", 2, nr, 3);
        if (ng == 3 && nr == 3) begin
            check("b2b_gnt1_cycle", 2, gc[1] - gc[0], 1);
            check("b2b_gnt2_cycle", 2, gc[2] - gc[0], 5);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("b2b_lat%0d", i), 2, rc[i] - gc[i], 4);
                check($sformatf("b2b_rdata%0d", i), 2, rdv[i], 32'hAAAA_0001 + 32'(i));
            end
        end

        // Randomized traffic on all three configurations against the model.
        for (int d = 0; d < 3; d++)
            for (int w = 0; w < 16; w++)
                do_txn(d, 1'b1, 32'(w) * 4, 4'hF, $urandom, rd, er, gw, lt);
        fork
            rand_drive(0, 600);
            rand_drive(1, 600);
            rand_drive(2, 600);
        join
        repeat (10) @(posedge clk);
        check("drain", 0, 32'(g_mdl[0].q.size()), 0);
        check("drain", 1, 32'(g_mdl[1].q.size()), 0);
        check("drain", 2, 32'(g_mdl[2].q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/obi_data_mem_responder.md
Name: obi_data_mem_responder

Overview:
- Memory-side responder for the data-cache fill/request interface; answers data_req/data_gnt/data_rvalid transactions issued by the cache (or the core directly) toward memory.
- Word-addressed SRAM model with byte enables, programmable grant stall, fixed in-order read latency and an outstanding-transaction limit.
- Sits in the core testbench between the data cache memory port and the simulation memory, replacing the ideal zero-wait responder.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words; power of two, ≥ 2.
- RD_LATENCY, 2, cycles from the accepting clock edge to the data_rvalid_o cycle; ≥ 1.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions; 1..RD_LATENCY.
- GNT_STALL_CYCLES, 0, cycles data_req_i must be held high before data_gnt_o may assert; 0 = same-cycle grant.

Ports:
- clk  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- data_req_i  input  1  transaction request.
- data_addr_i  input  32  byte address; word index = data_addr_i[AW+1:2], AW = log2(MEM_WORDS).
- data_we_i  input  1  1 = store, 0 = load.
- data_be_i  input  4  byte enables for stores.
- data_wdata_i  input  32  store data.
- data_gnt_o  output  1  request accepted this cycle.
- data_rvalid_o  output  1  response valid, one cycle per transaction.
- data_rdata_o  output  32  load data; 0 for stores and errors.
- data_err_o  output  1  response error; valid only with data_rvalid_o.

Behaviour:
- Reset (async assert, sync deassert): data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0, outstanding=0, stall counter=0, response pipeline flushed. The memory array is not reset.
- data_gnt_o is combinational: data_req_i && (stall_cnt == GNT_STALL_CYCLES) && (outstanding < MAX_OUTSTANDING).
- Acceptance occurs at a rising edge where data_req_i && data_gnt_o. At most one acceptance per cycle.
- The stall counter increments each cycle data_req_i=1 and the counter is below GNT_STALL_CYCLES. It clears on acceptance or when data_req_i=0.
- Out of range: any address with data_addr_i[31:AW+2] != 0. The transaction is still granted and answered, with data_err_o=1, no write and rdata=0. Address bits [1:0] are ignored.
- Store: on the acceptance edge, byte k of the word is written with data_wdata_i[8k+7:8k] when data_be_i[k]=1. be=0000 writes nothing but still gets a response.
- Load: the word is sampled on the acceptance edge. A store accepted earlier is visible; no later store affects it.
- Response pipeline: a RD_LATENCY-deep shift register of {valid, rdata, err}. Stage 0 is loaded at the acceptance edge. data_rvalid_o/data_rdata_o/data_err_o are driven from the last stage, so rvalid asserts exactly RD_LATENCY cycles after the acceptance edge.
- Stores also produce rvalid, with rdata=0. Responses are strictly in order and fixed-latency, so they never collide.
- Outstanding counter: +1 on acceptance, −1 on the rvalid cycle. Both in the same cycle leave it unchanged. It never exceeds MAX_OUTSTANDING and never underflows.
- When outstanding=MAX_OUTSTANDING, gnt stays low even if a response retires in that cycle; it reasserts the next cycle.
- Request changes while ungranted (address, we, etc.) are tolerated. Attributes are sampled only at acceptance.
- Reset mid-operation: all pending responses are discarded, and no rvalid is issued for pre-reset transactions. Memory contents are retained.

Test Plan:
- Defaults; store 0xDEADBEEF to addr 0x10 with be=1111, then load 0x10 → gnt in the request cycle; load rvalid 2 cycles after acceptance with rdata=0xDEADBEEF, err=0.
- Store 0x0000AA00 to 0x10 with be=0010, then load → rdata=0xDEADAAEF; the store response has rvalid with rdata=0.
- GNT_STALL_CYCLES=2, hold req high → gnt asserts in the 3rd cycle of req. Drop req after 1 cycle → stall counter clears and the next request again waits 2 cycles.
- RD_LATENCY=4, MAX_OUTSTANDING=2, three back-to-back loads → first two granted on consecutive cycles; the third waits until the cycle after the first rvalid; three rvalids return in issue order.
- Load addr 0x0000_1000 (MEM_WORDS=1024) → granted; rvalid with err=1, rdata=0. Store to the same address → err=1 and memory unchanged.
- Accept two loads, assert rst_i for 1 cycle before any rvalid → no rvalid after reset, outstanding=0, and a fresh load returns correct pre-reset memory data.
